// File: rtl/link_sync_pkg.sv
// rtl/link_sync_pkg.sv - shared state encoding and symbol constants for the link sync controller
package link_sync_pkg;

  typedef enum logic [1:0] {
    LOS      = 2'd0,
    ACQ      = 2'd1,
    SYNC     = 2'd2,
    SYNC_ERR = 2'd3
  } sync_state_t;

  localparam logic [7:0] K28_5       = 8'hBC;
  localparam logic       RD_INIT_VAL = 1'b0;

endpackage

// File: rtl/link_sync_sat_cnt.sv
// rtl/link_sync_sat_cnt.sv - saturating up-counter with clear priority
module link_sync_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/link_sync_ctrl.sv
// rtl/link_sync_ctrl.sv - 8b10b decoder sequencing and loss-of-sync / acquire / in-sync state machine
// Define LINK_SYNC_STATS_EN to build the loss-of-sync event counter behind los_count.
module link_sync_ctrl
  import link_sync_pkg::*;
#(
  parameter int BYTES     = 2,
  parameter int COMMA_CNT = 3,
  parameter int ERR_LIMIT = 4,
  parameter int GOOD_RUN  = 4,
  parameter int ERRCNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sym_vld,
  input  logic                  resync,
  input  logic                  stat_clr,
  input  logic [BYTES-1:0]      dec_k_char,
  input  logic [8*BYTES-1:0]    dec_data,
  input  logic [BYTES-1:0]      dec_code_err_bus,
  input  logic [BYTES-1:0]      dec_rd_err_bus,
  output logic                  dec_enable,
  output logic                  dec_init_rd_n,
  output logic                  dec_init_rd_val,
  output logic                  word_vld,
  output logic                  sync_ok,
  output logic                  los_evt,
  output logic [1:0]            state_o,
  output logic [ERRCNT_W-1:0]   err_total,
  output logic [7:0]            los_count
);

  localparam logic [3:0] COMMA_N = 4'(COMMA_CNT);
  localparam logic [3:0] ERR_N   = 4'(ERR_LIMIT);
  localparam logic [3:0] RUN_N   = 4'(GOOD_RUN);

  sync_state_t state;
  logic        st_vld;
  logic        bad;
  logic        comma;
  logic        good;
  logic [3:0]  acq_cnt;
  logic [3:0]  err_cnt;
  logic [3:0]  run_cnt;
  logic        unused_lanes;

  // Decoder has a fixed one-cycle latency, so its status belongs to last cycle's strobe.
  assign dec_enable      = sym_vld;
  assign dec_init_rd_val = RD_INIT_VAL;
  assign bad             = st_vld & ((|dec_code_err_bus) | (|dec_rd_err_bus));
  assign comma           = st_vld & ~bad & dec_k_char[0] & (dec_data[7:0] == K28_5);
  assign good            = st_vld & ~bad;
  assign word_vld        = st_vld & sync_ok & ~bad;
  assign state_o         = state;
  assign unused_lanes    = ^{dec_data, dec_k_char};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_vld <= 1'b0;
    else     st_vld <= sym_vld;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= LOS;
      acq_cnt       <= '0;
      err_cnt       <= '0;
      run_cnt       <= '0;
      sync_ok       <= 1'b0;
      los_evt       <= 1'b0;
      dec_init_rd_n <= 1'b0;
    end else begin
      los_evt       <= 1'b0;
      dec_init_rd_n <= 1'b1;
      if (resync) begin
        state         <= LOS;
        acq_cnt       <= '0;
        err_cnt       <= '0;
        run_cnt       <= '0;
        sync_ok       <= 1'b0;
        dec_init_rd_n <= 1'b0;
      end else begin
        case (state)
          LOS: if (comma) begin
            if (COMMA_CNT == 1) begin
              state   <= SYNC;
              sync_ok <= 1'b1;
            end else begin
              state   <= ACQ;
              acq_cnt <= 4'd1;
            end
          end
          ACQ: if (bad) begin
            state         <= LOS;
            acq_cnt       <= '0;
            dec_init_rd_n <= 1'b0;
          end else if (comma) begin
            if (acq_cnt + 4'd1 == COMMA_N) begin
              state   <= SYNC;
              sync_ok <= 1'b1;
              acq_cnt <= '0;
            end else begin
              acq_cnt <= acq_cnt + 4'd1;
            end
          end
          SYNC: if (bad) begin
            state   <= SYNC_ERR;
            err_cnt <= 4'd1;
            run_cnt <= '0;
          end
          SYNC_ERR: if (bad) begin
            run_cnt <= '0;
            if (err_cnt + 4'd1 == ERR_N) begin
              state         <= LOS;
              sync_ok       <= 1'b0;
              los_evt       <= 1'b1;
              dec_init_rd_n <= 1'b0;
              err_cnt       <= '0;
            end else begin
              err_cnt <= err_cnt + 4'd1;
            end
          end else if (good) begin
            // A full run of good words retires one outstanding error.
            if (run_cnt + 4'd1 == RUN_N) begin
              run_cnt <= '0;
              err_cnt <= err_cnt - 4'd1;
              if (err_cnt == 4'd1) state <= SYNC;
            end else begin
              run_cnt <= run_cnt + 4'd1;
            end
          end
          default: state <= LOS;
        endcase
      end
    end
  end

  link_sync_sat_cnt #(.W(ERRCNT_W)) u_err_total (
    .clk (clk),
    .rst (rst),
    .inc (bad & sync_ok),
    .clr (stat_clr),
    .cnt (err_total)
  );

`ifdef LINK_SYNC_STATS_EN
  logic los_inc;

  // Count both error-driven drops and software resyncs taken from an in-sync state.
  assign los_inc = (resync & sync_ok) |
                   (~resync & (state == SYNC_ERR) & bad & (err_cnt + 4'd1 == ERR_N));

  link_sync_sat_cnt #(.W(8)) u_los_count (
    .clk (clk),
    .rst (rst),
    .inc (los_inc),
    .clr (stat_clr),
    .cnt (los_count)
  );
`else
  assign los_count = 8'd0;
`endif

endmodule

// File: tb/tb_link_sync_ctrl.sv
// tb/tb_link_sync_ctrl.sv - randomized self-checking bench for link_sync_ctrl against a word-level model
module tb_link_sync_ctrl;

  localparam int BYTES     = 2;
  localparam int COMMA_CNT = 3;
  localparam int ERR_LIMIT = 4;
  localparam int GOOD_RUN  = 4;
  localparam int ERRCNT_W  = 4;

  localparam int S_LOS  = 0;
  localparam int S_ACQ  = 1;
  localparam int S_SYNC = 2;
  localparam int S_SERR = 3;

  // word kinds: 0 comma, 1 good non-comma, 2 code err, 3 rd err, 4 mixed errs, 5 0xBC without K flag
  localparam int W_COMMA = 0;
  localparam int W_GOOD  = 1;
  localparam int W_CERR  = 2;
  localparam int W_RERR  = 3;
  localparam int W_MIX   = 4;
  localparam int W_BCNK  = 5;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 sym_vld = 1'b0;
  logic                 resync = 1'b0;
  logic                 stat_clr = 1'b0;
  logic [BYTES-1:0]     dec_k_char = '0;
  logic [8*BYTES-1:0]   dec_data = '0;
  logic [BYTES-1:0]     dec_code_err_bus = '0;
  logic [BYTES-1:0]     dec_rd_err_bus = '0;
  logic                 dec_enable;
  logic                 dec_init_rd_n;
  logic                 dec_init_rd_val;
  logic                 word_vld;
  logic                 sync_ok;
  logic                 los_evt;
  logic [1:0]           state_o;
  logic [ERRCNT_W-1:0]  err_total;
  logic [7:0]           los_count;

  int n_checks = 0;
  int n_bad    = 0;
  int cyc      = 0;

  int                   m_st;
  int                   m_acq;
  int                   m_err;
  int                   m_run;
  logic                 m_sync_ok;
  logic                 m_evt;
  logic                 m_init_n;
  logic                 m_st_vld;
  logic [ERRCNT_W-1:0]  m_etot;
  logic [7:0]           m_losc;

  link_sync_ctrl #(
    .BYTES(BYTES), .COMMA_CNT(COMMA_CNT), .ERR_LIMIT(ERR_LIMIT),
    .GOOD_RUN(GOOD_RUN), .ERRCNT_W(ERRCNT_W)
  ) dut (
    .clk(clk), .rst(rst), .sym_vld(sym_vld), .resync(resync), .stat_clr(stat_clr),
    .dec_k_char(dec_k_char), .dec_data(dec_data),
    .dec_code_err_bus(dec_code_err_bus), .dec_rd_err_bus(dec_rd_err_bus),
    .dec_enable(dec_enable), .dec_init_rd_n(dec_init_rd_n), .dec_init_rd_val(dec_init_rd_val),
    .word_vld(word_vld), .sync_ok(sync_ok), .los_evt(los_evt), .state_o(state_o),
    .err_total(err_total), .los_count(los_count)
  );

  always #5 clk = ~clk;

  task automatic gen_word(input int kind, output logic [BYTES-1:0] k,
                          output logic [8*BYTES-1:0] d, output logic [BYTES-1:0] c,
                          output logic [BYTES-1:0] r);
    int lane;
    for (int i = 0; i < BYTES; i++) begin
      d[8*i +: 8] = 8'($urandom);
      k[i]        = 1'($urandom);
    end
    c = '0;
    r = '0;
    lane = $urandom_range(BYTES-1, 0);
    case (kind)
      W_COMMA: begin k[0] = 1'b1; d[7:0] = 8'hBC; end
      W_GOOD:  if (d[7:0] == 8'hBC) d[7:0] = 8'hBD;
      W_CERR:  c[lane] = 1'b1;
      W_RERR:  r[lane] = 1'b1;
      W_BCNK:  begin k[0] = 1'b0; d[7:0] = 8'hBC; end
      default: begin
        c = BYTES'($urandom);
        r = BYTES'($urandom);
        if (c == '0 && r == '0) c[0] = 1'b1;
      end
    endcase
  endtask

  // One clock: drive inputs, check combinational outputs, advance model and check registered outputs.
  task automatic step(input logic sv, input logic rs, input logic clr, input int kind);
    logic [BYTES-1:0]   k, c, r;
    logic [8*BYTES-1:0] d;
    logic b, cm, g, exp_wv, evt, enter, inc_los;
    int   nst;
    gen_word(kind, k, d, c, r);
    sym_vld = sv; resync = rs; stat_clr = clr;
    dec_k_char = k; dec_data = d; dec_code_err_bus = c; dec_rd_err_bus = r;
    b      = m_st_vld && (c != '0 || r != '0);
    cm     = m_st_vld && !b && k[0] && (d[7:0] == 8'hBC);
    g      = m_st_vld && !b;
    exp_wv = g && m_sync_ok;
    #1;
    n_checks++;
    if (dec_enable !== sv) begin
      n_bad++; $display("FAIL dec_enable cyc=%0d got=%b want=%b", cyc, dec_enable, sv);
    end
    n_checks++;
    if (word_vld !== exp_wv) begin
      n_bad++; $display("FAIL word_vld cyc=%0d got=%b want=%b", cyc, word_vld, exp_wv);
    end
    @(posedge clk);
    cyc++;
    nst = m_st; evt = 1'b0; enter = 1'b0; inc_los = 1'b0;
    if (rs) begin
      inc_los = (m_st == S_SYNC || m_st == S_SERR);
      nst = S_LOS; m_acq = 0; m_err = 0; m_run = 0; enter = 1'b1;
    end else begin
      case (m_st)
        S_LOS: if (cm) begin
          m_acq = 1;
          if (m_acq >= COMMA_CNT) begin nst = S_SYNC; m_acq = 0; end
          else nst = S_ACQ;
        end
        S_ACQ: if (b) begin
          nst = S_LOS; m_acq = 0; enter = 1'b1;
        end else if (cm) begin
          m_acq++;
          if (m_acq >= COMMA_CNT) begin nst = S_SYNC; m_acq = 0; end
        end
        S_SYNC: if (b) begin nst = S_SERR; m_err = 1; m_run = 0; end
        default: if (b) begin
          m_err++; m_run = 0;
          if (m_err >= ERR_LIMIT) begin
            nst = S_LOS; m_err = 0; evt = 1'b1; enter = 1'b1; inc_los = 1'b1;
          end
        end else if (g) begin
          m_run++;
          if (m_run >= GOOD_RUN) begin
            m_run = 0; m_err--;
            if (m_err == 0) nst = S_SYNC;
          end
        end
      endcase
    end
    if (clr) m_etot = '0;
    else if (b && m_sync_ok && m_etot != '1) m_etot++;
`ifdef LINK_SYNC_STATS_EN
    if (clr) m_losc = '0;
    else if (inc_los && m_losc != 8'hFF) m_losc++;
`else
    m_losc = '0;
`endif
    m_st = nst; m_sync_ok = (nst >= S_SYNC); m_evt = evt; m_init_n = !enter; m_st_vld = sv;
    #1;
    n_checks++;
    if (state_o !== 2'(m_st)) begin
      n_bad++; $display("FAIL state cyc=%0d got=%0d want=%0d", cyc, state_o, m_st);
    end
    n_checks++;
    if (sync_ok !== m_sync_ok) begin
      n_bad++; $display("FAIL sync_ok cyc=%0d got=%b want=%b", cyc, sync_ok, m_sync_ok);
    end
    n_checks++;
    if (los_evt !== m_evt) begin
      n_bad++; $display("FAIL los_evt cyc=%0d got=%b want=%b", cyc, los_evt, m_evt);
    end
    n_checks++;
    if (dec_init_rd_n !== m_init_n) begin
      n_bad++; $display("FAIL init_rd_n cyc=%0d got=%b want=%b", cyc, dec_init_rd_n, m_init_n);
    end
    n_checks++;
    if (err_total !== m_etot) begin
      n_bad++; $display("FAIL err_total cyc=%0d got=%0d want=%0d", cyc, err_total, m_etot);
    end
    n_checks++;
    if (los_count !== m_losc) begin
      n_bad++; $display("FAIL los_count cyc=%0d got=%0d want=%0d", cyc, los_count, m_losc);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; sym_vld = 1'b0; resync = 1'b0; stat_clr = 1'b0;
    dec_k_char = '0; dec_data = '0; dec_code_err_bus = '0; dec_rd_err_bus = '0;
    #1;
    n_checks++;
    if ({state_o, sync_ok, los_evt, word_vld, dec_init_rd_n, dec_init_rd_val} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_outputs got=%b%b%b%b%b%b want=0000000", state_o, sync_ok, los_evt,
               word_vld, dec_init_rd_n, dec_init_rd_val);
    end
    n_checks++;
    if (err_total !== '0 || los_count !== 8'd0) begin
      n_bad++; $display("FAIL reset_counters got=%0d/%0d want=0/0", err_total, los_count);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_st = S_LOS; m_acq = 0; m_err = 0; m_run = 0;
    m_sync_ok = 1'b0; m_evt = 1'b0; m_init_n = 1'b0; m_st_vld = 1'b0;
    m_etot = '0; m_losc = '0;
    #1;
    n_checks++;
    if (dec_init_rd_n !== 1'b0) begin
      n_bad++; $display("FAIL init_held_after_release got=%b want=0", dec_init_rd_n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    step(1'b1, 1'b0, 1'b0, W_CERR);
  endtask

  task automatic test_acquire();
    step(1'b1, 1'b0, 1'b0, W_COMMA);
    n_checks++;
    if (state_o !== 2'd1) begin
      n_bad++; $display("FAIL acq_first_comma got=%0d want=1", state_o);
    end
    step(1'b1, 1'b0, 1'b0, W_COMMA);
    step(1'b1, 1'b0, 1'b0, W_COMMA);
    n_checks++;
    if (state_o !== 2'd2 || sync_ok !== 1'b1) begin
      n_bad++; $display("FAIL acq_to_sync got=%0d/%b want=2/1", state_o, sync_ok);
    end
    step(1'b1, 1'b0, 1'b0, W_GOOD);
    step(1'b1, 1'b0, 1'b0, W_BCNK);
  endtask

  task automatic test_sync_err_recover();
    step(1'b1, 1'b0, 1'b0, W_CERR);
    n_checks++;
    if (state_o !== 2'd3) begin
      n_bad++; $display("FAIL sync_err_entry got=%0d want=3", state_o);
    end
    for (int i = 0; i < GOOD_RUN; i++) step(1'b1, 1'b0, 1'b0, (i == 1) ? W_BCNK : W_GOOD);
    n_checks++;
    if (state_o !== 2'd2 || err_total !== 4'd1) begin
      n_bad++; $display("FAIL sync_err_recover got=%0d/%0d want=2/1", state_o, err_total);
    end
  endtask

  task automatic test_los();
    step(1'b1, 1'b0, 1'b1, W_GOOD);
    for (int i = 0; i < ERR_LIMIT; i++) step(1'b1, 1'b0, 1'b0, W_RERR);
    n_checks++;
    if (los_evt !== 1'b1 || dec_init_rd_n !== 1'b0 || sync_ok !== 1'b0 || err_total !== 4'd4) begin
      n_bad++;
      $display("FAIL los_drop got=evt%b init%b ok%b err%0d want=evt1 init0 ok0 err4",
               los_evt, dec_init_rd_n, sync_ok, err_total);
    end
    step(1'b1, 1'b0, 1'b0, W_GOOD);
  endtask

  task automatic test_acq_bad();
    step(1'b1, 1'b0, 1'b0, W_COMMA);
    step(1'b1, 1'b0, 1'b0, W_COMMA);
    step(1'b1, 1'b0, 1'b0, W_CERR);
    n_checks++;
    if (state_o !== 2'd0 || dec_init_rd_n !== 1'b0) begin
      n_bad++; $display("FAIL acq_bad got=%0d/%b want=0/0", state_o, dec_init_rd_n);
    end
    step(1'b1, 1'b0, 1'b0, W_COMMA);
    step(1'b1, 1'b0, 1'b0, W_COMMA);
    n_checks++;
    if (state_o !== 2'd1) begin
      n_bad++; $display("FAIL acq_restart got=%0d want=1", state_o);
    end
    step(1'b1, 1'b0, 1'b0, W_COMMA);
  endtask

  task automatic test_resync();
    logic [7:0] want;
    step(1'b1, 1'b0, 1'b1, W_GOOD);
    step(1'b1, 1'b1, 1'b0, W_CERR);
`ifdef LINK_SYNC_STATS_EN
    want = 8'd1;
`else
    want = 8'd0;
`endif
    n_checks++;
    if (state_o !== 2'd0 || los_evt !== 1'b0 || los_count !== want) begin
      n_bad++;
      $display("FAIL resync got=st%0d evt%b cnt%0d want=st0 evt0 cnt%0d",
               state_o, los_evt, los_count, want);
    end
    step(1'b1, 1'b0, 1'b0, W_GOOD);
  endtask

  task automatic test_saturate();
    step(1'b1, 1'b0, 1'b1, W_GOOD);
    for (int r = 0; r < 7; r++) begin
      for (int i = 0; i < COMMA_CNT; i++) step(1'b1, 1'b0, 1'b0, W_COMMA);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, W_CERR);
      step(1'b1, 1'b1, 1'b0, W_GOOD);
    end
    n_checks++;
    if (err_total !== 4'd15) begin
      n_bad++; $display("FAIL err_saturate got=%0d want=15", err_total);
    end
    for (int i = 0; i < COMMA_CNT; i++) step(1'b1, 1'b0, 1'b0, W_COMMA);
    step(1'b1, 1'b0, 1'b1, W_RERR);
    n_checks++;
    if (err_total !== 4'd0) begin
      n_bad++; $display("FAIL clr_beats_inc got=%0d want=0", err_total);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, 1'b0, W_CERR);
    do_reset();
    step(1'b1, 1'b0, 1'b0, W_COMMA);
    for (int i = 0; i < COMMA_CNT; i++) step(1'b1, 1'b0, 1'b0, W_COMMA);
  endtask

  task automatic test_random();
    int p, kind;
    logic sv, rs, clr;
    for (int n = 0; n < 1500; n++) begin
      sv  = ($urandom_range(99, 0) < 85);
      rs  = ($urandom_range(99, 0) < 2);
      clr = ($urandom_range(99, 0) < 2);
      p   = $urandom_range(99, 0);
      if      (p < 40) kind = W_COMMA;
      else if (p < 72) kind = W_GOOD;
      else if (p < 80) kind = W_BCNK;
      else if (p < 87) kind = W_CERR;
      else if (p < 94) kind = W_RERR;
      else             kind = W_MIX;
      step(sv, rs, clr, kind);
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_acquire();
    test_sync_err_recover();
    test_los();
    test_acq_bad();
    test_resync();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
